// File: rtl/band_mixer.sv
// rtl/band_mixer.sv - masks equalizer bands, sums them through a registered adder tree, shifts and saturates.
// Also keeps a sticky clip flag and a saturating clip-event counter.
module band_mixer #(
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int FILTER_OUT_BITS   = 16,
  parameter int MIX_OUT_BITS      = 16,
  parameter int OUT_SHIFT         = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         en,
  input  logic                                         in_valid,
  input  logic [NUMBER_OF_FILTERS-1:0]                 band_mask,
  input  logic [NUMBER_OF_FILTERS*FILTER_OUT_BITS-1:0] filter_outs,
  input  logic                                         clear_overflow,
  output logic [MIX_OUT_BITS-1:0]                      mix_out,
  output logic                                         out_valid,
  output logic                                         overflow,
  output logic [15:0]                                  sat_count
);

  localparam int N   = NUMBER_OF_FILTERS;
  localparam int FOB = FILTER_OUT_BITS;
  localparam int MOB = MIX_OUT_BITS;
  localparam int L   = (N > 1) ? $clog2(N) : 0;
  localparam int P   = 1 << L;
  localparam int W   = FOB + L;
  localparam int CW  = ((W > MOB) ? W : MOB) + 1;

  localparam logic signed [CW-1:0] SMAX = {{(CW-MOB+1){1'b0}}, {(MOB-1){1'b1}}};
  localparam logic signed [CW-1:0] SMIN = {{(CW-MOB+1){1'b1}}, {(MOB-1){1'b0}}};

  // Heap-ordered tree: node[1] is the root, node[P..2P-1] are the stage-0 leaves.
  logic signed [W-1:0] node [1:2*P-1];
  logic signed [W-1:0] leaf [0:P-1];
  logic        [L:0]   vld;

  logic signed [W-1:0]  shifted;
  logic signed [CW-1:0] s_ext;
  logic                 clamp_hi;
  logic                 clamp_lo;
  logic [MOB-1:0]       mix_d;
  logic                 sat_event;

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N) begin : g_band
      assign leaf[i] = band_mask[i] ? W'($signed(filter_outs[i*FOB +: FOB])) : '0;
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < 2*P; k++) node[k] <= '0;
      vld       <= '0;
      mix_out   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (in_valid) begin
        for (int i = 0; i < P; i++) node[P+i] <= leaf[i];
      end
      for (int k = 1; k < P; k++) node[k] <= node[2*k] + node[2*k+1];
      vld[0] <= in_valid;
      for (int l = 1; l <= L; l++) vld[l] <= vld[l-1];
      mix_out   <= mix_d;
      out_valid <= vld[L];
    end
  end

  // Compare in a width that holds both the full sum and the output limits.
  always_comb begin
    shifted  = node[1] >>> OUT_SHIFT;
    s_ext    = CW'(shifted);
    clamp_hi = s_ext > SMAX;
    clamp_lo = s_ext < SMIN;
    mix_d    = s_ext[MOB-1:0];
    if (clamp_hi) mix_d = SMAX[MOB-1:0];
    else if (clamp_lo) mix_d = SMIN[MOB-1:0];
  end

  assign sat_event = en & vld[L] & (clamp_hi | clamp_lo);

  // A clip in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      sat_count <= '0;
    end else if (sat_event) begin
      overflow <= 1'b1;
      if (clear_overflow) sat_count <= 16'd1;
      else if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
    end else if (clear_overflow) begin
      overflow  <= 1'b0;
      sat_count <= '0;
    end
  end

endmodule

// File: tb/tb_band_mixer.sv
// tb/tb_band_mixer.sv - directed and random checks of band_mixer against a queue-based sum/clamp model.
module tb_band_mixer;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic         clear_overflow = 1'b0;
  logic [7:0]   band_mask = '0;
  logic [127:0] filter_outs = '0;
  logic [15:0]  mix_out, mix_out2, sat_count, sat_count2;
  logic         out_valid, out_valid2, overflow, overflow2;

  always #5 clk = ~clk;

  band_mixer dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .band_mask(band_mask),
    .filter_outs(filter_outs), .clear_overflow(clear_overflow), .mix_out(mix_out),
    .out_valid(out_valid), .overflow(overflow), .sat_count(sat_count)
  );

  band_mixer #(.OUT_SHIFT(3)) dut_sh (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .band_mask(band_mask),
    .filter_outs(filter_outs), .clear_overflow(clear_overflow), .mix_out(mix_out2),
    .out_valid(out_valid2), .overflow(overflow2), .sat_count(sat_count2)
  );

  typedef struct {int v1; bit c1; int v2; bit c2; int due;} exp_t;
  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   en_edges = 0;
  int   m_cnt [2];
  bit   m_ov [2];
  bit   exp_vld;
  int   exp_mix;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [127:0] f, input logic [7:0] m, input int sh,
                                output int v, output bit clip);
    longint s = 0;
    for (int i = 0; i < 8; i++)
      if (m[i]) s += longint'($signed(f[i*16 +: 16]));
    s = s >>> sh;
    clip = 1'b1;
    if (s > 32767) v = 32767;
    else if (s < -32768) v = -32768;
    else begin v = int'(s); clip = 1'b0; end
  endfunction

  task automatic bump(input int i);
    m_ov[i] = 1'b1;
    if (m_cnt[i] < 65535) m_cnt[i]++;
  endtask

  task automatic tick();
    bit e, c;
    exp_t x;
    e = en;
    c = clear_overflow;
    if (e && in_valid && !rst) begin
      model(filter_outs, band_mask, 0, x.v1, x.c1);
      model(filter_outs, band_mask, 3, x.v2, x.c2);
      x.due = en_edges + LAT;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    if (rst) return;
    if (c) begin m_cnt = '{0, 0}; m_ov = '{0, 0}; end
    if (e) begin
      en_edges++;
      exp_vld = (q.size() > 0 && q[0].due == en_edges);
      if (exp_vld) begin
        x = q.pop_front();
        exp_mix = x.v1;
        chk("out_valid", out_valid, 1);
        chk("mix_out", $signed(mix_out), x.v1);
        chk("out_valid_sh", out_valid2, 1);
        chk("mix_out_sh", $signed(mix_out2), x.v2);
        if (x.c1) bump(0);
        if (x.c2) bump(1);
      end else begin
        chk("out_valid_idle", out_valid, 0);
        chk("out_valid_idle_sh", out_valid2, 0);
      end
    end else begin
      chk("hold_valid", out_valid, exp_vld);
      if (exp_vld) chk("hold_mix", $signed(mix_out), exp_mix);
    end
    chk("overflow", overflow, m_ov[0]);
    chk("sat_count", sat_count, m_cnt[0]);
    chk("overflow_sh", overflow2, m_ov[1]);
    chk("sat_count_sh", sat_count2, m_cnt[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    q.delete();
    m_cnt = '{0, 0};
    m_ov = '{0, 0};
    exp_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_mix_out", mix_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sat_count", sat_count, 0);
    rst = 1'b0;
  endtask

  task automatic set_all(input logic [15:0] k);
    for (int i = 0; i < 8; i++) filter_outs[i*16 +: 16] = k;
  endtask

  task automatic pulse();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    m_cnt = '{0, 0};
    m_ov = '{0, 0};
    exp_vld = 1'b0;
    exp_mix = 0;
    do_reset();
    en = 1'b1;

    // basic sum, then clipping in both directions
    set_all(16'd1000); band_mask = 8'hFF; pulse(); drain(6);
    set_all(16'd32767); pulse(); drain(6);
    chk("sat_pos_ovf", overflow, 1);
    chk("sat_pos_cnt", sat_count, 1);
    chk("shift3_no_ovf", overflow2, 0);
    set_all(16'h8000); pulse(); drain(6);
    chk("sat_neg_cnt", sat_count, 2);

    // masking
    set_all(16'd30000); filter_outs[15:0] = 16'hFFFB; band_mask = 8'h01; pulse(); drain(6);
    band_mask = 8'h00; pulse(); drain(6);

    // back-to-back with an enable gap
    band_mask = 8'hFF;
    for (int k = 1; k <= 10; k++) begin
      set_all(16'(k));
      in_valid = 1'b1;
      tick();
      if (k == 4) begin
        set_all(16'd99);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
      end
    end
    drain(8);

    // random traffic
    for (int t = 0; t < 300; t++) begin
      en = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      band_mask = 8'($urandom);
      for (int i = 0; i < 8; i++)
        filter_outs[i*16 +: 16] = (t % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 4000) - 2000);
      clear_overflow = ($urandom_range(0, 19) == 0);
      tick();
    end
    clear_overflow = 1'b0;
    en = 1'b1;
    drain(8);

    // reset with three samples in flight
    set_all(16'd7); band_mask = 8'hFF;
    in_valid = 1'b1;
    repeat (3) tick();
    do_reset();
    drain(10);
    set_all(16'd12); pulse(); drain(6);

    // clear coinciding with a clip
    set_all(16'd32767); pulse(); drain(6);
    pulse(); drain(3);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clr_evt_ovf", overflow, 1);
    chk("clr_evt_cnt", sat_count, 1);
    drain(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
